// File: rtl/irq_arbiter_if.sv
// Bus bundle between the memory-mapped I/O decode / CP0 side and irq_arbiter.
// The master drives sources, register strobes and the CP0 handshake; the slave is the arbiter.
interface irq_arbiter_if #(
    parameter int N_SRC = 8
);
    logic [N_SRC-1:0] irq_src;
    logic             cfg_wen;
    logic [1:0]       cfg_addr;
    logic [31:0]      cfg_wdata;
    logic [31:0]      cfg_rdata;
    logic             ir_ack;
    logic             eret;
    logic             ir_in;
    logic [4:0]       irq_id;
    logic             busy;

    modport master (
        output irq_src, cfg_wen, cfg_addr, cfg_wdata, ir_ack, eret,
        input  cfg_rdata, ir_in, irq_id, busy
    );

    modport slave (
        input  irq_src, cfg_wen, cfg_addr, cfg_wdata, ir_ack, eret,
        output cfg_rdata, ir_in, irq_id, busy
    );
endinterface

// File: rtl/irq_arbiter.sv
// Prioritised external-interrupt arbiter feeding the CP0 ir_in line: edge capture,
// mask/pending/cause/ctrl registers, and an IDLE/REQ/SERVICE request tracker.
module irq_arbiter #(
    parameter int N_SRC = 8
) (
    input  logic          clk,
    input  logic          rst,
    irq_arbiter_if.slave  bus
);

    localparam logic [1:0] ADDR_MASK    = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_CAUSE   = 2'd2;
    localparam logic [1:0] ADDR_CTRL    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [N_SRC-1:0] s1;
    logic [N_SRC-1:0] s2;
    logic [N_SRC-1:0] s3;
    logic [N_SRC-1:0] rise;

    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] pending_nx;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] id_onehot;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] ack_clr;

    logic             ge;
    logic             cause_vld;
    logic [4:0]       cause_id;
    logic [4:0]       sel;
    logic [4:0]       irq_id_r;
    logic             ir_in_r;
    logic             busy_r;

    logic             any_elig;
    logic             id_elig;
    logic             take_ack;
    logic             latch_req;
    logic             eret_done;

    logic             unused_wdata;

    // Lowest set index wins: source 0 has the highest priority.
    function automatic logic [4:0] lowest_set(input logic [N_SRC-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    assign unused_wdata = ^bus.cfg_wdata;

    // ---- stage: synchronise and detect rising edges ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= bus.irq_src;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise     = s2 & ~s3;
    assign eligible = pending & mask;
    assign any_elig = |eligible;
    assign sel      = lowest_set(eligible);

    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            id_onehot[i] = (irq_id_r == 5'(i));
        end
    end

    assign id_elig = |(eligible & id_onehot);

    // ---- stage: request tracker ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        take_ack  = 1'b0;
        latch_req = 1'b0;
        eret_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ge && any_elig) begin
                    state_nx  = ST_REQ;
                    latch_req = 1'b1;
                end
            end
            ST_REQ: begin
                // Acknowledge beats a simultaneous withdrawal; no pre-emption once latched.
                if (bus.ir_ack) begin
                    state_nx = ST_SERVICE;
                    take_ack = 1'b1;
                end else if (!ge || !id_elig) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (bus.eret) begin
                    state_nx  = ST_IDLE;
                    eret_done = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // ---- stage: software-visible registers ----
    assign w1c     = (bus.cfg_wen && bus.cfg_addr == ADDR_PENDING) ? bus.cfg_wdata[N_SRC-1:0] : '0;
    assign ack_clr = take_ack ? id_onehot : '0;

    // A new edge in the same cycle as a clear leaves the bit set.
    assign pending_nx = (pending & ~w1c & ~ack_clr) | rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask      <= '0;
            pending   <= '0;
            ge        <= 1'b0;
            cause_vld <= 1'b0;
            cause_id  <= '0;
        end else begin
            pending <= pending_nx;
            if (bus.cfg_wen && bus.cfg_addr == ADDR_MASK) mask <= bus.cfg_wdata[N_SRC-1:0];
            if (bus.cfg_wen && bus.cfg_addr == ADDR_CTRL) ge <= bus.cfg_wdata[0];
            if (take_ack) begin
                cause_vld <= 1'b1;
                cause_id  <= irq_id_r;
            end else if (eret_done) begin
                cause_vld <= 1'b0;
            end
        end
    end

    // ---- stage: registered outputs ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_in_r  <= 1'b0;
            busy_r   <= 1'b0;
            irq_id_r <= '0;
        end else begin
            ir_in_r <= (state_nx == ST_REQ);
            busy_r  <= (state_nx != ST_IDLE);
            if (latch_req) irq_id_r <= sel;
        end
    end

    assign bus.ir_in  = ir_in_r;
    assign bus.busy   = busy_r;
    assign bus.irq_id = irq_id_r;

    always_comb begin
        bus.cfg_rdata = '0;
        case (bus.cfg_addr)
            ADDR_MASK:    bus.cfg_rdata = 32'(mask);
            ADDR_PENDING: bus.cfg_rdata = 32'(pending);
            ADDR_CAUSE:   bus.cfg_rdata = {cause_vld, 26'b0, cause_id};
            ADDR_CTRL:    bus.cfg_rdata = {31'b0, ge};
            default:      bus.cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_arbiter.sv
module tb_irq_arbiter;

  localparam int K_REG  = 0;
  localparam int K_IRIN = 1;
  localparam int K_ID   = 2;
  localparam int K_BUSY = 3;

  logic clk;
  logic rst;

  irq_arbiter_if #(.N_SRC(8)) bus ();

  irq_arbiter #(.N_SRC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic report(input string n, input logic [31:0] a, input logic [31:0] e);
    failures++;
    $display("FAIL %s actual=0x%08h required=0x%08h", n, a, e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_wen   = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    @(posedge clk);
    #1;
    bus.cfg_wen   = 1'b0;
  endtask

  task automatic chk_reg(input logic [1:0] a, input logic [31:0] e, input string n);
    bus.cfg_addr = a;
    #1;
    checks++;
    if (bus.cfg_rdata !== e) report(n, bus.cfg_rdata, e);
    #1;
  endtask

  task automatic chk_out(input int k, input logic [31:0] e, input string n);
    checks++;
    case (k)
      K_IRIN: begin
        if ({31'b0, bus.ir_in} !== e) report(n, {31'b0, bus.ir_in}, e);
      end
      K_ID: begin
        if ({27'b0, bus.irq_id} !== e) report(n, {27'b0, bus.irq_id}, e);
      end
      K_BUSY: begin
        if ({31'b0, bus.busy} !== e) report(n, {31'b0, bus.busy}, e);
      end
      default: begin
        if (bus.cfg_rdata !== e) report(n, bus.cfg_rdata, e);
      end
    endcase
    #2;
  endtask

  task automatic pulse_ack();
    bus.ir_ack = 1'b1;
    tick(1);
    bus.ir_ack = 1'b0;
  endtask

  task automatic pulse_eret();
    bus.eret = 1'b1;
    tick(1);
    bus.eret = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.irq_src   = '0;
    bus.cfg_wen   = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    bus.ir_ack    = 1'b0;
    bus.eret      = 1'b0;
    tick(2);
    rst = 1'b0;

    chk_reg(2'd0, 32'h0, "rst_mask");
    chk_reg(2'd1, 32'h0, "rst_pending");
    chk_reg(2'd2, 32'h0, "rst_cause");
    chk_reg(2'd3, 32'h0, "rst_ctrl");
    chk_out(K_IRIN, 32'd0, "rst_ir_in");
    chk_out(K_BUSY, 32'd0, "rst_busy");
    chk_out(K_ID,   32'd0, "rst_irq_id");

    wr(2'd0, 32'h0000_00FF);
    wr(2'd3, 32'h0000_0001);
    chk_reg(2'd0, 32'hFF, "t1_mask");
    chk_reg(2'd3, 32'h1, "t1_ctrl");
    bus.irq_src[3] = 1'b1;
    tick(2);
    chk_reg(2'd1, 32'h00, "t1_pending_e1");
    tick(1);
    bus.irq_src[3] = 1'b0;
    chk_reg(2'd1, 32'h08, "t1_pending_e2");
    chk_out(K_IRIN, 32'd0, "t1_ir_in_e2");
    tick(1);
    chk_out(K_IRIN, 32'd1, "t1_ir_in_e3");
    chk_out(K_ID,   32'd3, "t1_irq_id_e3");
    chk_out(K_BUSY, 32'd1, "t1_busy_e3");
    pulse_ack();
    chk_out(K_IRIN, 32'd0, "t1_ir_in_ack");
    chk_out(K_BUSY, 32'd1, "t1_busy_ack");
    chk_reg(2'd1, 32'h00, "t1_pending_ack");
    chk_reg(2'd2, 32'h8000_0003, "t1_cause_ack");
    pulse_eret();
    chk_out(K_BUSY, 32'd0, "t1_busy_eret");
    chk_reg(2'd2, 32'h0000_0003, "t1_cause_eret");

    bus.irq_src[5] = 1'b1;
    bus.irq_src[2] = 1'b1;
    tick(3);
    bus.irq_src[5] = 1'b0;
    bus.irq_src[2] = 1'b0;
    chk_reg(2'd1, 32'h24, "t2_pending");
    tick(1);
    chk_out(K_IRIN, 32'd1, "t2_ir_in");
    chk_out(K_ID,   32'd2, "t2_irq_id");
    pulse_ack();
    chk_reg(2'd2, 32'h8000_0002, "t2_cause_ack");
    chk_reg(2'd1, 32'h20, "t2_pending_ack");
    chk_out(K_IRIN, 32'd0, "t2_ir_in_ack");
    pulse_eret();
    chk_out(K_BUSY, 32'd0, "t2_busy_eret");
    chk_out(K_IRIN, 32'd0, "t2_ir_in_eret");
    tick(1);
    chk_out(K_IRIN, 32'd1, "t2_ir_in_second");
    chk_out(K_ID,   32'd5, "t2_irq_id_second");
    pulse_ack();
    chk_reg(2'd1, 32'h00, "t2_pending_second_ack");
    chk_reg(2'd2, 32'h8000_0005, "t2_cause_second_ack");
    pulse_eret();

    bus.irq_src[4] = 1'b1;
    tick(4);
    bus.irq_src[4] = 1'b0;
    chk_out(K_IRIN, 32'd1, "t3_ir_in");
    chk_out(K_ID,   32'd4, "t3_irq_id");
    wr(2'd1, 32'h0000_0010);
    chk_reg(2'd1, 32'h00, "t3_pending_w1c");
    tick(1);
    chk_out(K_IRIN, 32'd0, "t3_ir_in_withdrawn");
    chk_out(K_BUSY, 32'd0, "t3_busy_withdrawn");

    bus.irq_src[6] = 1'b1;
    tick(4);
    bus.irq_src[6] = 1'b0;
    chk_out(K_ID, 32'd6, "t4_irq_id");
    pulse_ack();
    bus.irq_src[0] = 1'b1;
    tick(3);
    bus.irq_src[0] = 1'b0;
    chk_reg(2'd1, 32'h01, "t4_pending_in_service");
    chk_out(K_IRIN, 32'd0, "t4_ir_in_in_service");
    chk_out(K_BUSY, 32'd1, "t4_busy_in_service");
    tick(2);
    chk_out(K_IRIN, 32'd0, "t4_ir_in_still_service");
    pulse_eret();
    chk_out(K_IRIN, 32'd0, "t4_ir_in_eret");
    tick(1);
    chk_out(K_IRIN, 32'd1, "t4_ir_in_after_eret");
    chk_out(K_ID,   32'd0, "t4_irq_id_after_eret");
    pulse_ack();
    pulse_eret();

    wr(2'd3, 32'h0000_0000);
    bus.irq_src[1] = 1'b1;
    tick(4);
    bus.irq_src[1] = 1'b0;
    chk_reg(2'd1, 32'h02, "t5_pending_ge0");
    chk_out(K_IRIN, 32'd0, "t5_ir_in_ge0");
    chk_out(K_BUSY, 32'd0, "t5_busy_ge0");
    wr(2'd3, 32'hFFFF_FFFF);
    chk_reg(2'd3, 32'h1, "t5_ctrl_upper_bits");
    chk_out(K_IRIN, 32'd0, "t5_ir_in_at_ge_write");
    tick(1);
    chk_out(K_IRIN, 32'd1, "t5_ir_in_ge1");
    chk_out(K_ID,   32'd1, "t5_irq_id_ge1");
    bus.ir_ack = 1'b1;
    wr(2'd1, 32'h0000_0002);
    bus.ir_ack = 1'b0;
    chk_out(K_BUSY, 32'd1, "t5_busy_ack_w1c");
    chk_out(K_IRIN, 32'd0, "t5_ir_in_ack_w1c");
    chk_reg(2'd1, 32'h00, "t5_pending_ack_w1c");
    chk_reg(2'd2, 32'h8000_0001, "t5_cause_ack_w1c");

    bus.irq_src[7] = 1'b1;
    tick(3);
    chk_reg(2'd1, 32'h80, "t6_pending_pre_rst");
    rst = 1'b1;
    #1;
    chk_out(K_IRIN, 32'd0, "t6_ir_in_rst");
    chk_out(K_BUSY, 32'd0, "t6_busy_rst");
    chk_out(K_ID,   32'd0, "t6_irq_id_rst");
    chk_reg(2'd2, 32'h0, "t6_cause_rst");
    chk_reg(2'd1, 32'h0, "t6_pending_rst");
    chk_reg(2'd0, 32'h0, "t6_mask_rst");
    chk_reg(2'd3, 32'h0, "t6_ctrl_rst");
    tick(2);
    rst = 1'b0;
    tick(5);
    wr(2'd1, 32'h0000_0080);
    tick(3);
    chk_reg(2'd1, 32'h00, "t6_held_no_repend");
    chk_out(K_IRIN, 32'd0, "t6_ir_in_after_rst");
    bus.irq_src[7] = 1'b0;
    tick(3);
    bus.irq_src[7] = 1'b1;
    tick(3);
    chk_reg(2'd1, 32'h80, "t6_toggle_repend");
    wr(2'd0, 32'hFFFF_FFFF);
    chk_reg(2'd0, 32'hFF, "t6_mask_upper_bits");

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
